// File: rtl/simmem_rdata_responder.sv
// Simulated-memory R-channel responder: queues AR requests and
// answers each with a capped burst of R beats in acceptance order.
package simmem_pkg;

  localparam int MaxRBurstLen = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [25:0] addr;
    logic [7:0]  burst_length;
    logic [2:0]  burst_size;
    logic [1:0]  burst_type;
    logic [3:0]  qos;
  } raddr_req_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] data;
    logic [1:0]  response;
    logic        last;
  } rdata_fields_t;

  typedef union packed {
    rdata_fields_t all_fields;
  } rdata_t;

endpackage

module simmem_rdata_responder
  import simmem_pkg::*;
#(
  parameter int QueueDepth = 4,
  parameter int MaxBeats   = MaxRBurstLen
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           raddr_in_valid_i,
  output logic                           raddr_in_ready_o,
  input  logic [$bits(raddr_req_t)-1:0]  raddr_i,
  output logic                           rdata_out_valid_o,
  input  logic                           rdata_out_ready_i,
  output logic [$bits(rdata_t)-1:0]      rdata_o,
  output logic [$clog2(QueueDepth+2)-1:0] pending_cnt_o
);

  localparam int PtrW = $clog2(QueueDepth);
  localparam int CntW = $clog2(QueueDepth + 1);
  localparam int PcW  = $clog2(QueueDepth + 2);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e state_q, state_d;

  logic [$bits(raddr_req_t)-1:0] mem_q [QueueDepth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [3:0]  id_q, id_d;
  logic [15:0] base_q, base_d;
  logic [8:0]  nb_q, nb_d;
  logic [8:0]  beat_q, beat_d;

  raddr_req_t head;
  logic [8:0] len9, head_nb;
  logic       full, empty, push, pop;
  logic       last, r_hs;
  rdata_t     beat;

  always_comb begin
    head  = raddr_req_t'(mem_q[rptr_q]);
    full  = (cnt_q == CntW'(QueueDepth));
    empty = (cnt_q == '0);
    push  = raddr_in_valid_i && !rst_i && !full;
    len9  = {1'b0, head.burst_length} + 9'd1;
    // lengths beyond the cap are truncated, not split
    head_nb = (len9 > 9'(MaxBeats)) ? 9'(MaxBeats) : len9;
    last  = (beat_q == nb_q - 9'd1);
    r_hs  = (state_q == BURST) && rdata_out_ready_i;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    base_d  = base_q;
    nb_d    = nb_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (r_hs) begin
          if (!last) begin
            beat_d = beat_q + 9'd1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      id_d   = head.id;
      base_d = head.addr[15:0];
      nb_d   = head_nb;
      beat_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= raddr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      base_q  <= '0;
      nb_q    <= 9'd1;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      base_q  <= base_d;
      nb_q    <= nb_d;
      beat_q  <= beat_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_comb begin
    beat                     = '0;
    beat.all_fields.id       = id_q;
    beat.all_fields.data     = base_q + 16'(beat_q);
    beat.all_fields.response = 2'b00;
    beat.all_fields.last     = last;
  end

  assign raddr_in_ready_o  = !rst_i && !full;
  assign rdata_out_valid_o = !rst_i && (state_q == BURST);
  assign rdata_o = rdata_out_valid_o ? beat : '0;
  assign pending_cnt_o = rst_i ? '0 :
    PcW'(cnt_q) + PcW'(state_q == BURST);

endmodule

// File: tb/tb_simmem_rdata_responder.sv
// Directed bench for simmem_rdata_responder: latency, cap/wrap,
// backpressure, FIFO fill with back-to-back bursts, mid-burst reset.
module tb_simmem_rdata_responder;
  import simmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        ar_v;
  logic        ar_r;
  logic [46:0] ar;
  logic        r_v;
  logic        r_r;
  logic [22:0] rd;
  logic [2:0]  pend;

  int nc;
  int nf;

  simmem_rdata_responder dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .raddr_in_valid_i  (ar_v),
    .raddr_in_ready_o  (ar_r),
    .raddr_i           (ar),
    .rdata_out_valid_o (r_v),
    .rdata_out_ready_i (r_r),
    .rdata_o           (rd),
    .pending_cnt_o     (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [46:0] mk(
    input logic [3:0] id, input logic [25:0] a, input logic [7:0] len);
    raddr_req_t q;
    q.id = id;
    q.addr = a;
    q.burst_length = len;
    q.burst_size = 3'd2;
    q.burst_type = 2'd1;
    q.qos = 4'hA;
    return q;
  endfunction

  // expected R word: {id, data, resp=0, last}
  function automatic logic [22:0] rw(
    input logic [3:0] id, input logic [15:0] d, input logic l);
    return {id, d, 2'b00, l};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ar_v = 1'b1;
    ar = mk(4'd9, 26'h55, 8'd0);
    r_r = 1'b1;
    repeat (3) @(negedge clk);
    nc++;
    if (ar_r !== 1'b0) begin
      nf++; $display("FAIL rst_ready got %b want 0", ar_r);
    end
    nc++;
    if (r_v !== 1'b0 || rd !== 23'd0) begin
      nf++; $display("FAIL rst_r got v=%b d=%h want 0/0", r_v, rd);
    end
    nc++;
    if (pend !== 3'd0) begin
      nf++; $display("FAIL rst_pend got %0d want 0", pend);
    end
    ar_v = 1'b0;
    rst = 1'b0;
    #1;
    nc++;
    if (ar_r !== 1'b1) begin
      nf++; $display("FAIL post_rst_ready got %b want 1", ar_r);
    end
    repeat (3) @(negedge clk);
    nc++;
    if (r_v !== 1'b0 || pend !== 3'd0) begin
      nf++; $display("FAIL rst_no_accept got v=%b p=%0d want 0/0", r_v, pend);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    r_r = 1'b1;
    ar_v = 1'b1;
    ar = mk(4'd3, 26'h0100, 8'd2);
    @(negedge clk);
    ar_v = 1'b0;
    nc++;
    if (r_v !== 1'b0 || pend !== 3'd1) begin
      nf++; $display("FAIL single_n1 got v=%b p=%0d want 0/1", r_v, pend);
    end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      nc++;
      if (r_v !== 1'b1 || rd !== rw(4'd3, 16'h0100 + 16'(b), b == 2)) begin
        nf++;
        $display("FAIL single_beat%0d got v=%b d=%h want 1/%h",
                 b, r_v, rd, rw(4'd3, 16'h0100 + 16'(b), b == 2));
      end
    end
    @(negedge clk);
    nc++;
    if (r_v !== 1'b0 || pend !== 3'd0) begin
      nf++; $display("FAIL single_end got v=%b p=%0d want 0/0", r_v, pend);
    end
  endtask

  task automatic test_cap_wrap();
    logic [15:0] ed [4];
    ed[0] = 16'hFFFE; ed[1] = 16'hFFFF; ed[2] = 16'h0000; ed[3] = 16'h0001;
    @(negedge clk);
    r_r = 1'b1;
    ar_v = 1'b1;
    ar = mk(4'd7, 26'h3FFFFFE, 8'd255);
    @(negedge clk);
    ar_v = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      nc++;
      if (r_v !== 1'b1 || rd !== rw(4'd7, ed[b], b == 3)) begin
        nf++;
        $display("FAIL cap_beat%0d got v=%b d=%h want 1/%h",
                 b, r_v, rd, rw(4'd7, ed[b], b == 3));
      end
    end
    @(negedge clk);
    nc++;
    if (r_v !== 1'b0) begin
      nf++; $display("FAIL cap_end got v=%b want 0", r_v);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    r_r = 1'b0;
    ar_v = 1'b1;
    ar = mk(4'd5, 26'h0200, 8'd2);
    @(negedge clk);
    ar_v = 1'b0;
    @(negedge clk);
    nc++;
    if (r_v !== 1'b1 || rd !== rw(4'd5, 16'h0200, 1'b0)) begin
      nf++; $display("FAIL bp_beat0 got v=%b d=%h", r_v, rd);
    end
    r_r = 1'b1;
    @(negedge clk);
    r_r = 1'b0;
    for (int c = 0; c < 5; c++) begin
      nc++;
      if (r_v !== 1'b1 || rd !== rw(4'd5, 16'h0201, 1'b0)) begin
        nf++;
        $display("FAIL bp_hold%0d got v=%b d=%h want 1/%h",
                 c, r_v, rd, rw(4'd5, 16'h0201, 1'b0));
      end
      @(negedge clk);
    end
    r_r = 1'b1;
    @(negedge clk);
    nc++;
    if (r_v !== 1'b1 || rd !== rw(4'd5, 16'h0202, 1'b1)) begin
      nf++; $display("FAIL bp_beat2 got v=%b d=%h", r_v, rd);
    end
    @(negedge clk);
    nc++;
    if (r_v !== 1'b0) begin
      nf++; $display("FAIL bp_end got v=%b want 0", r_v);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    r_r = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      ar_v = 1'b1;
      ar = mk(4'(i), 26'(i * 16'h1000), 8'd1);
      nc++;
      if (ar_r !== 1'b1) begin
        nf++; $display("FAIL fill_ready%0d got %b want 1", i, ar_r);
      end
      @(negedge clk);
    end
    ar_v = 1'b0;
    nc++;
    if (ar_r !== 1'b0 || pend !== 3'd5) begin
      nf++; $display("FAIL fill_full got r=%b p=%0d want 0/5", ar_r, pend);
    end
    r_r = 1'b1;
    for (int k = 0; k < 10; k++) begin
      nc++;
      if (r_v !== 1'b1 ||
          rd !== rw(4'(k / 2 + 1), 16'((k / 2 + 1) * 16'h1000 + k % 2),
                    k % 2 == 1)) begin
        nf++;
        $display("FAIL b2b_beat%0d got v=%b d=%h", k, r_v, rd);
      end
      @(negedge clk);
    end
    nc++;
    if (r_v !== 1'b0 || pend !== 3'd0) begin
      nf++; $display("FAIL b2b_end got v=%b p=%0d want 0/0", r_v, pend);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    r_r = 1'b1;
    ar_v = 1'b1;
    ar = mk(4'd6, 26'h0300, 8'd2);
    @(negedge clk);
    ar = mk(4'd8, 26'h0400, 8'd0);
    @(negedge clk);
    ar_v = 1'b0;
    nc++;
    if (r_v !== 1'b1 || rd !== rw(4'd6, 16'h0300, 1'b0)) begin
      nf++; $display("FAIL rm_beat0 got v=%b d=%h", r_v, rd);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    nc++;
    if (r_v !== 1'b0 || rd !== 23'd0 || pend !== 3'd0) begin
      nf++; $display("FAIL rm_drop got v=%b d=%h p=%0d", r_v, rd, pend);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nc++;
      if (r_v !== 1'b0 || pend !== 3'd0) begin
        nf++; $display("FAIL rm_quiet%0d got v=%b p=%0d", c, r_v, pend);
      end
    end
    ar_v = 1'b1;
    ar = mk(4'd2, 26'h0ABC, 8'd0);
    @(negedge clk);
    ar_v = 1'b0;
    @(negedge clk);
    nc++;
    if (r_v !== 1'b1 || rd !== rw(4'd2, 16'h0ABC, 1'b1)) begin
      nf++; $display("FAIL rm_new got v=%b d=%h", r_v, rd);
    end
    @(negedge clk);
  endtask

  initial begin
    nc = 0;
    nf = 0;
    rst = 1'b1;
    ar_v = 1'b0;
    ar = '0;
    r_r = 1'b0;
    test_reset();
    test_single();
    test_cap_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
